// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner selection for one shared UART TX engine.
// A requester is chosen in IDLE, its byte is latched and a single-cycle
// tx_start is issued once the engine is free; ownership is held until the
// engine reports tx_done.
// Optional build macro: UART_TX_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts a frame after TIMEOUT_CYC cycles without tx_done.
module uart_tx_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_W      = 8,
    parameter  int TIMEOUT_CYC = 2048,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [ID_W-1:0]           owner,
    output logic                      active,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [ID_W-1:0]     pick;
    logic                any_req;
    logic                expire;

    logic [NUM_REQ-1:0]  grant_nxt;
    logic                tx_start_nxt;
    logic [DATA_W-1:0]   tx_data_nxt;
    logic [ID_W-1:0]     owner_nxt;
    logic                active_nxt;
    logic                timeout_nxt;

    // Unpack the flat byte bus so the selected byte can be indexed directly.
    logic [DATA_W-1:0]   req_byte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_byte[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Round-robin search starting just after ptr; scanning from the farthest
    // candidate back toward ptr+1 lets the nearest set request win last.
    always_comb begin
        logic [ID_W-1:0] idx;
        pick    = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Watchdog counts WAIT cycles; it sits at zero outside WAIT so it is
    // already clear on WAIT entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (state != WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    // A same-cycle tx_done wins over expiry, so no error is raised then.
    assign expire = (state == WAIT) && !tx_done &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; only IDLE looks at req, only WAIT looks at tx_done.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)           state_nxt = START;
            START:   if (!tx_busy)          state_nxt = WAIT;
            WAIT:    if (tx_done || expire) state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Output logic: computes the values the output registers load next edge.
    always_comb begin
        grant_nxt    = '0;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        owner_nxt    = owner;
        timeout_nxt  = expire;
        ptr_nxt      = ptr;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt[pick] = 1'b1;
                    tx_data_nxt     = req_byte[pick];
                    owner_nxt       = pick;
                end
            end
            START:   tx_start_nxt = !tx_busy;
            // The finished (or stalled) owner becomes the lowest priority.
            WAIT:    if (tx_done || expire) ptr_nxt = owner;
            default: ;
        endcase
        active_nxt = (state_nxt != IDLE);
    end

    // Output and priority-pointer registers; ptr resets so requester 0 leads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            owner       <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
            ptr         <= ID_W'(NUM_REQ - 1);
        end else begin
            grant       <= grant_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            owner       <= owner_nxt;
            active      <= active_nxt;
            timeout_err <= timeout_nxt;
            ptr         <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a frame-level model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TO_CYC  = 16;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        grant;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy = 1'b0;
    logic                      tx_done = 1'b0;
    logic [ID_W-1:0]           owner;
    logic                      active;
    logic                      timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .owner(owner),
        .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- frame-level reference model ----------------
    // A frame is "owned" from grant until done/abort and "launched" once the
    // engine was told to start. Priority: smallest forward distance from the
    // last finished owner.
    logic [NUM_REQ-1:0] e_grant = '0;
    bit                 e_start = 1'b0;
    bit                 e_err   = 1'b0;
    bit                 own     = 1'b0;
    bit                 launched = 1'b0;
    int                 e_owner = 0;
    int                 m_ptr   = NUM_REQ - 1;
    logic [DATA_W-1:0]  e_data  = '0;
    int                 cyc     = 0;
    int                 w_entry = 0;
    int                 k;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
        int best = -1;
        int bd   = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            int d;
            d = (i - p - 1 + 2 * NUM_REQ) % NUM_REQ;
            if (r[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            e_grant = '0; e_start = 0; e_err = 0; own = 0; launched = 0;
            e_owner = 0; m_ptr = NUM_REQ - 1; e_data = '0;
        end else begin
            cyc++;
            e_grant = '0; e_start = 0; e_err = 0;
            if (!own) begin
                k = rr_pick(req, m_ptr);
                if (k >= 0) begin
                    e_grant[k] = 1'b1;
                    e_owner    = k;
                    e_data     = req_data[k*DATA_W +: DATA_W];
                    own        = 1;
                    launched   = 0;
                end
            end else if (!launched) begin
                if (!tx_busy) begin
                    e_start  = 1;
                    launched = 1;
                    w_entry  = cyc;
                end
            end else if (tx_done) begin
                own   = 0;
                m_ptr = e_owner;
            end
`ifdef UART_TX_TIMEOUT_EN
            else if (cyc - w_entry == TO_CYC) begin
                own   = 0;
                m_ptr = e_owner;
                e_err = 1;
            end
`endif
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_grant",    int'(grant),       int'(e_grant));
            check("m_tx_start", int'(tx_start),    int'(e_start));
            check("m_tx_data",  int'(tx_data),     int'(e_data));
            check("m_owner",    int'(owner),       e_owner);
            check("m_active",   int'(active),      int'(own));
            check("m_timeout",  int'(timeout_err), int'(e_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        req = '0; tx_busy = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Wait for a grant, check its index, wait for tx_start, then complete it.
    task automatic do_frame(input int exp_k, input string nm);
        int  gk = -1;
        bit  s  = 1'b0;
        for (int c = 0; c < 40 && gk < 0; c++) begin
            @(negedge clk);
            if (grant != 0) gk = $clog2(grant);
        end
        check(nm, gk, exp_k);
        for (int c = 0; c < 40 && !s; c++) begin
            @(negedge clk);
            s = tx_start;
        end
        check({nm, "_start"}, int'(s), 1);
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Test 1: reset values, then a single frame from requester 1.
        repeat (3) @(negedge clk);
        check("rst_grant",    int'(grant), 0);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data",  int'(tx_data), 0);
        check("rst_owner",    int'(owner), 0);
        check("rst_active",   int'(active), 0);
        check("rst_timeout",  int'(timeout_err), 0);
        reset = 1'b1;
        req = 4'b0010;
        req_data = 32'h0000_5A00;
        chk_en = 1'b1;
        @(negedge clk);
        check("t1_grant",  int'(grant), 2);
        check("t1_data",   int'(tx_data), 'h5A);
        check("t1_owner",  int'(owner), 1);
        check("t1_active", int'(active), 1);
        check("t1_nostart", int'(tx_start), 0);
        req = '0;
        @(negedge clk);
        check("t1_start", int'(tx_start), 1);
        check("t1_grant_pulse", int'(grant), 0);
        repeat (108) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("t1_active_fall", int'(active), 0);
        check("t1_owner_hold", int'(owner), 1);

        // Test 2: all requesting, strict rotation.
        do_reset();
        req = 4'b1111;
        req_data = 32'h4433_2211;
        do_frame(0, "t2_g0");
        do_frame(1, "t2_g1");
        do_frame(2, "t2_g2");
        do_frame(3, "t2_g3");
        do_frame(0, "t2_g4");

        // Test 3: two requesters alternate.
        do_reset();
        req = 4'b0101;
        do_frame(0, "t3_g0");
        do_frame(2, "t3_g1");
        do_frame(0, "t3_g2");
        do_frame(2, "t3_g3");

        // Test 4: busy engine delays tx_start.
        do_reset();
        req = 4'b0001;
        tx_busy = 1'b1;
        @(negedge clk);
        check("t4_grant", int'(grant), 1);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_held", int'(tx_start), 0);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        check("t4_start", int'(tx_start), 1);
        @(negedge clk);
        check("t4_start_pulse", int'(tx_start), 0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;

        // Test 5: reset in WAIT clears everything immediately.
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("t5_owner", int'(owner), 2);
        check("t5_active", int'(active), 1);
        #2 reset = 1'b0;
        #1;
        check("t5_grant",   int'(grant), 0);
        check("t5_start",   int'(tx_start), 0);
        check("t5_data",    int'(tx_data), 0);
        check("t5_owner0",  int'(owner), 0);
        check("t5_active0", int'(active), 0);
        check("t5_timeout", int'(timeout_err), 0);
        @(negedge clk);
        reset = 1'b1;
        req = 4'b1111;
        do_frame(0, "t5_first");

`ifdef UART_TX_TIMEOUT_EN
        // Test 6: watchdog aborts a stalled frame; owner loses its turn.
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        check("t6_grant", int'(grant), 2);
        req = 4'b1010;
        @(negedge clk);
        check("t6_start", int'(tx_start), 1);
        for (int n = 1; n <= TO_CYC; n++) begin
            @(negedge clk);
            if (n < TO_CYC) begin
                check("t6_no_err", int'(timeout_err), 0);
            end else begin
                check("t6_err", int'(timeout_err), 1);
                check("t6_active", int'(active), 0);
            end
        end
        do_frame(3, "t6_next");
`endif

        // Randomized phase: requesters obey the handshake, engine is random.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    if (grant[i]) begin
                        if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                        else req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            end
            tx_busy = ($urandom_range(3, 0) == 0);
            tx_done = ($urandom_range(7, 0) == 0);
        end
        @(negedge clk);
        req = '0; tx_busy = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmit engine between NUM_REQ requesters.
- Each frame on the line is 11 bits: start, 8 data, parity, stop.
- Sits between the requesting client blocks and the TX engine.
- Selects one requester, latches its byte, and issues a one-cycle start to the engine.
- Holds ownership until the engine reports frame completion.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data byte width per requester
ID_W, $clog2(NUM_REQ), width of owner index (derived, not overridden)
TIMEOUT_CYC, 2048, watchdog limit in clk cycles (used only with UART_TX_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NUM_REQ  per-requester transmit request, level
req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
grant  output  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted
tx_start  output  1  one-cycle pulse to TX engine to begin a frame
tx_data  output  DATA_W  latched byte presented to TX engine
tx_busy  input  1  TX engine is shifting a frame
tx_done  input  1  one-cycle pulse from TX engine when stop bit completes
owner  output  ID_W  index of current or last granted requester
active  output  1  high while a frame is owned (states START and WAIT)
timeout_err  output  1  one-cycle pulse on watchdog abort (0 when feature absent)

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, tx_start=0, tx_data=0, owner=0, active=0, timeout_err=0.
- Reset also sets ptr=NUM_REQ-1, so requester 0 has first priority after reset.
- FSM states: IDLE, START, WAIT. All outputs are registered.
- IDLE, |req=1:
  - Pick the first set req[k], searching ptr+1, ptr+2, … modulo NUM_REQ.
  - Next edge: grant[k]=1 for exactly one cycle, tx_data=req_data[k], owner=k, active=1, state=START.
- IDLE, |req=0: stay in IDLE.
- START, tx_busy=0: tx_start=1 for one cycle, state=WAIT.
- START, tx_busy=1: tx_start is withheld and the FSM stays in START until tx_busy=0.
- WAIT, tx_done=1: state=IDLE, active=0, ptr=owner.
- Latency:
  - req sampled at edge N gives grant at edge N+1 and tx_start at edge N+2 (engine idle).
  - After tx_done is sampled, the earliest next grant is two edges later (IDLE evaluation cycle).
- Requester handshake:
  - req_data must be stable while req=1 and until grant.
  - The requester drops req in the cycle after grant unless it has another byte.
  - If req stays high, the next frame for that requester is arbitrated normally in round-robin order.
- req changes while in START or WAIT are ignored; only IDLE arbitrates.
- tx_done while in IDLE or START is ignored.
- tx_done and a new req in the same cycle: the done is processed first, and the req is arbitrated in the following IDLE cycle.
- A requester dropping req after grant does not affect the frame in flight.
- Reset mid-frame: the FSM aborts immediately and all outputs clear. The engine shares the same reset.
- owner holds its value through IDLE; it changes only on a new grant.

Optional Feature:
UART_TX_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to WAIT and increments every WAIT cycle.
  - If the count reaches TIMEOUT_CYC-1 without tx_done, the FSM goes to IDLE and timeout_err pulses one cycle.
  - active=0 and ptr=owner, so the stalled requester loses its turn.
  - tx_done on the same cycle as expiry takes precedence: no error.
- Not defined: no counter is built, WAIT waits indefinitely for tx_done, and timeout_err is tied to 0.

Test Plan:
1. After reset, req=4'b0010 with byte 0x5A (tx_busy low) -> grant=4'b0010 one cycle after req is sampled; tx_data=0x5A, owner=1; tx_start pulses the next cycle. tx_done 110 cycles later -> active falls the next edge.
2. req=4'b1111 held, each frame completed by tx_done -> grants in order 0,1,2,3,0.
3. req=4'b0101 held continuously -> grants alternate 0,2,0,2; no grant to 1 or 3.
4. tx_busy held high for 5 cycles after grant -> tx_start stays 0 for those 5 cycles, then pulses once on the first cycle tx_busy=0.
5. reset driven low mid-WAIT with owner=2 -> all outputs 0 immediately. After release with req=4'b1111 -> first grant goes to requester 0.
6. With UART_TX_TIMEOUT_EN and TIMEOUT_CYC=16, no tx_done -> timeout_err pulses 16 cycles after entering WAIT and active=0. With req=4'b1010 the next grant goes to 3 when owner was 1.
